// File: rtl/button_pkg.sv
// Shared types and constants for the button reader: debounce FSM states,
// counter widths and parameter legality limits.
package button_pkg;

    typedef enum logic {
        REL = 1'b0,
        PRS = 1'b1
    } btn_state_e;

    localparam int unsigned SC_W = 4;
    localparam int unsigned RC_W = 6;

    localparam int unsigned NBTN_MAX   = 8;
    localparam int unsigned STABLE_MIN = 2;
    localparam int unsigned STABLE_MAX = 15;

endpackage

// File: rtl/button_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability counter,
// and an auto-repeat counter when BTN_AUTOREPEAT_EN is defined.
module button_chan
    import button_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8
`endif
) (
    input  logic clk,
    input  logic NOTRESET,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [SC_W-1:0] ScLast = SC_W'(STABLE_TICKS - 1);

    logic            r_sync1;
    logic            r_sync2;
    btn_state_e      r_state;
    btn_state_e      w_state_d;
    logic [SC_W-1:0] r_sc;
    logic [SC_W-1:0] w_sc_d;
    logic            r_press;
    logic            w_press_d;
    logic            r_release;
    logic            w_release_d;
    logic            w_level;

    assign w_level = (r_state == PRS);

    always_comb begin
        w_state_d   = r_state;
        w_sc_d      = r_sc;
        w_press_d   = 1'b0;
        w_release_d = 1'b0;
        if (r_sync2 == w_level) begin
            w_sc_d = '0;
        end else if (i_tick) begin
            if (r_sc == ScLast) begin
                w_sc_d = '0;
                if (r_state == REL) begin
                    w_state_d = PRS;
                    w_press_d = 1'b1;
                end else begin
                    w_state_d   = REL;
                    w_release_d = 1'b1;
                end
            end else begin
                w_sc_d = r_sc + 1'b1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [RC_W-1:0] RcDelay  = RC_W'(REPEAT_DELAY);
    localparam logic [RC_W-1:0] RcReload = RC_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [RC_W-1:0] r_rc;
    logic [RC_W-1:0] w_rc_d;
    logic [RC_W-1:0] w_rc_inc;
    logic            w_repeat;

    assign w_rc_inc = r_rc + 1'b1;

    // Counter only runs while the channel stays in PRS; entry or exit clears it.
    always_comb begin
        w_rc_d   = '0;
        w_repeat = 1'b0;
        if (r_state == PRS && w_state_d == PRS) begin
            w_rc_d = r_rc;
            if (i_tick) begin
                if (w_rc_inc == RcDelay) begin
                    w_rc_d   = RcReload;
                    w_repeat = 1'b1;
                end else begin
                    w_rc_d = w_rc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            r_rc <= '0;
        end else begin
            r_rc <= w_rc_d;
        end
    end
`else
    logic w_repeat;
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= REL;
            r_sc      <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_state   <= w_state_d;
            r_sc      <= w_sc_d;
            r_press   <= w_press_d | w_repeat;
            r_release <= w_release_d;
        end
    end

    assign o_level   = w_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_reader.sv
// Debounced multi-channel button reader with a shared prescaler tick.
// Optional auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module button_reader
    import button_pkg::*;
#(
    parameter int unsigned NBTN         = 4,
    parameter int unsigned TICK_BIT     = 18,
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic            clk,
    input  logic            NOTRESET,
    input  logic [NBTN-1:0] BTN,
    output logic [NBTN-1:0] LEVEL,
    output logic [NBTN-1:0] PRESS,
    output logic [NBTN-1:0] RELEASE,
    output logic            TICK
);

    if (NBTN < 1 || NBTN > NBTN_MAX) begin : g_bad_nbtn
        $error("button_reader: NBTN out of range");
    end
    if (STABLE_TICKS < STABLE_MIN || STABLE_TICKS > STABLE_MAX) begin : g_bad_stable
        $error("button_reader: STABLE_TICKS out of range");
    end
    if (REPEAT_RATE == 0 || REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY >= (1 << RC_W))
    begin : g_bad_repeat
        $error("button_reader: REPEAT_DELAY/REPEAT_RATE out of range");
    end

    logic [TICK_BIT:0] r_presc;
    logic              w_tick;

    assign w_tick = &r_presc;

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign TICK = w_tick;

    for (genvar g = 0; g < NBTN; g++) begin : g_chan
        button_chan #(
            .STABLE_TICKS(STABLE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
`endif
        ) u_chan (
            .clk      (clk),
            .NOTRESET (NOTRESET),
            .i_btn    (BTN[g]),
            .i_tick   (w_tick),
            .o_level  (LEVEL[g]),
            .o_press  (PRESS[g]),
            .o_release(RELEASE[g])
        );
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader (TICK_BIT=2, STABLE_TICKS=4, NBTN=4) with an
// event scoreboard; the repeat section depends on BTN_AUTOREPEAT_EN.
module tb_button_reader;

    typedef struct packed {
        logic [3:0] press;
        logic [3:0] rel;
    } ev_t;

    logic       clk = 1'b0;
    logic       NOTRESET;
    logic [3:0] BTN;
    logic [3:0] LEVEL;
    logic [3:0] PRESS;
    logic [3:0] RELEASE;
    logic       TICK;

    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[$];
    int   press_cnt[4];
    int   rep_cnt[4];
    int   rel_cnt[4];
    int   excl_bad = 0;
    logic [3:0] ev_press;
    logic [3:0] ev_rep;

    always #5 clk = ~clk;

    button_reader #(
        .NBTN        (4),
        .TICK_BIT    (2),
        .STABLE_TICKS(4),
        .REPEAT_DELAY(4),
        .REPEAT_RATE (2)
    ) dut (
        .clk     (clk),
        .NOTRESET(NOTRESET),
        .BTN     (BTN),
        .LEVEL   (LEVEL),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .TICK    (TICK)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample at the falling edge; a PRESS while LEVEL
    // was already high is an auto-repeat, otherwise it is a fresh press.
    task automatic step();
        logic [3:0] prev;
        prev = LEVEL;
        @(negedge clk);
        ev_press = PRESS & ~prev;
        ev_rep   = PRESS & prev;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] += int'(ev_press[i]);
            rep_cnt[i]   += int'(ev_rep[i]);
            rel_cnt[i]   += int'(RELEASE[i]);
        end
        if ((PRESS & RELEASE) != 4'b0) excl_bad++;
    endtask

    task automatic wait_event(input string tag, input int budget, output int lat);
        ev_t e;
        int  n;
        n = 0;
        do begin
            step();
            n++;
        end while ((ev_press | RELEASE) == 4'b0 && n < budget);
        lat = n;
        check({tag, " queue"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " press"}, 32'(ev_press), 32'(e.press));
            check({tag, " release"}, 32'(RELEASE), 32'(e.rel));
        end
    endtask

    initial begin
        int lat;
        int n;
        int snap;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rep_cnt[i]   = 0;
            rel_cnt[i]   = 0;
        end
        ev_press = '0;
        ev_rep   = '0;
        NOTRESET = 1'b1;
        BTN      = 4'hF;
        #2 NOTRESET = 1'b0;
        repeat (3) step();
        check("reset LEVEL", 32'(LEVEL), 0);
        check("reset PRESS", 32'(PRESS), 0);
        check("reset RELEASE", 32'(RELEASE), 0);
        check("reset TICK", 32'(TICK), 0);

        BTN = 4'h0;
        NOTRESET = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!TICK && n < 20);
        check("first tick delay", n, 7);

        // Clean press on channel 0
        BTN[0] = 1'b1;
        exp_q.push_back(ev_t'{press: 4'b0001, rel: 4'b0000});
        wait_event("press0", 40, lat);
        check("press0 latency in 27..35", 32'(lat >= 27 && lat <= 35), 1);
        check("press0 LEVEL", 32'(LEVEL), 32'h1);
        repeat (20) step();
        check("press0 single pulse", press_cnt[0], 1);
        check("press0 no release", rel_cnt[0], 0);

        // Bounce on channel 1: never stable for 4 ticks
        for (int k = 0; k < 20; k++) begin
            BTN[1] = ~BTN[1];
            repeat (5) step();
        end
        BTN[1] = 1'b0;
        repeat (40) step();
        check("bounce LEVEL1", 32'(LEVEL[1]), 0);
        check("bounce press1", press_cnt[1], 0);
        check("bounce release1", rel_cnt[1], 0);

        // Release ch0 and press ch2 in the same cycle
        BTN[0] = 1'b0;
        BTN[2] = 1'b1;
        exp_q.push_back(ev_t'{press: 4'b0100, rel: 4'b0001});
        wait_event("simul", 40, lat);
        check("simul LEVEL", 32'(LEVEL), 32'h4);

        BTN[2] = 1'b0;
        exp_q.push_back(ev_t'{press: 4'b0000, rel: 4'b0100});
        wait_event("release2", 40, lat);
        check("release2 LEVEL", 32'(LEVEL), 32'h0);

        // Reset 20 clocks into a press on channel 3
        BTN[3] = 1'b1;
        repeat (20) step();
        NOTRESET = 1'b0;
        repeat (2) step();
        check("midreset LEVEL", 32'(LEVEL), 0);
        check("midreset no press3", press_cnt[3], 0);
        NOTRESET = 1'b1;
        exp_q.push_back(ev_t'{press: 4'b1000, rel: 4'b0000});
        wait_event("requal3", 40, lat);
        check("requal3 latency in 27..35", 32'(lat >= 27 && lat <= 35), 1);
        check("requal3 LEVEL", 32'(LEVEL), 32'h8);

`ifdef BTN_AUTOREPEAT_EN
        n = 0;
        do begin
            step();
            n++;
        end while (!ev_rep[3] && n < 40);
        check("repeat first gap", n, 32);
        n = 0;
        do begin
            step();
            n++;
        end while (!ev_rep[3] && n < 40);
        check("repeat second gap", n, 16);
        BTN[3] = 1'b0;
        n = 0;
        while (LEVEL[3] && n < 60) begin
            step();
            n++;
        end
        check("repeat LEVEL3 drop", 32'(LEVEL[3]), 0);
        snap = rep_cnt[3];
        repeat (60) step();
        check("repeat stops", rep_cnt[3], snap);
`else
        snap = 0;
        repeat (60) step();
        check("no repeat press3", press_cnt[3], 1);
        check("no repeat pulses", rep_cnt[0] + rep_cnt[1] + rep_cnt[2] + rep_cnt[3], snap);
`endif
        check("press/release exclusive", excl_bad, 0);
        check("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
